// File: rtl/exe_mem_pkg.sv
// exe_mem_pkg: shared types for the EXE->MEM pipeline buffer.
// Holds the default payload widths, the payload layout and the buffer state enum.
package exe_mem_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEST_W_DEF = 4;
    localparam int PC_W_DEF   = 32;

    // Payload layout at the default widths. The top packs its ports in this
    // same field order, so the flat vector and the struct line up bit for bit.
    typedef struct packed {
        logic                  wb_en;
        logic                  mem_r_en;
        logic                  mem_w_en;
        logic [DEST_W_DEF-1:0] dest;
        logic [PC_W_DEF-1:0]   pc;
        logic [DATA_W_DEF-1:0] alu_res;
        logic [DATA_W_DEF-1:0] val_rm;
    } exe_mem_payload_t;

    // Occupancy of the two-slot buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: generic two-slot valid/ready buffer (main + skid).
// in_ready comes straight from the state register, so the upstream ready
// never depends combinationally on out_ready. A flush empties both slots.
module pipe_skid_buf
    import exe_mem_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    buf_state_t   state, state_nxt;
    logic [W-1:0] main_q, skid_q;
    logic         accept, pop;
    logic         load_main_in, load_main_skid, load_skid;

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign accept    = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;

    // Next-state and slot-load decode; flush overrides every transition.
    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt    = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_nxt      = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        if (flush) begin
            state_nxt      = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    // Slot registers; the skid entry only ever moves into main, keeping FIFO order.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in)        main_q <= in_data;
            else if (load_main_skid) main_q <= skid_q;
            if (load_skid)           skid_q <= in_data;
        end
    end

endmodule

// File: rtl/exe_mem_pipe_buf.sv
// exe_mem_pipe_buf: EXE->MEM pipeline stage with valid/ready backpressure,
// a one-entry skid buffer and flush. Optional perf counters are enabled by
// defining EXE_MEM_PERF_EN.
module exe_mem_pipe_buf
    import exe_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEST_W = DEST_W_DEF,
    parameter int PC_W   = PC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic [DEST_W-1:0] dest_in,
    input  logic [PC_W-1:0]   pc_in,
    input  logic [DATA_W-1:0] alu_res_in,
    input  logic [DATA_W-1:0] val_rm_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wb_en_out,
    output logic              mem_r_en_out,
    output logic              mem_w_en_out,
    output logic [DEST_W-1:0] dest_out,
    output logic [PC_W-1:0]   pc_out,
    output logic [DATA_W-1:0] alu_res_out,
    output logic [DATA_W-1:0] val_rm_out
`ifdef EXE_MEM_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
`endif
);

    // Same field order as exe_mem_payload_t.
    localparam int W = 3 + DEST_W + PC_W + 2 * DATA_W;

    logic [W-1:0] in_data, out_data;
    logic         wb_en_raw, mem_r_en_raw, mem_w_en_raw;

    assign in_data = {wb_en_in, mem_r_en_in, mem_w_en_in, dest_in, pc_in,
                      alu_res_in, val_rm_in};

    pipe_skid_buf #(.W(W)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    assign {wb_en_raw, mem_r_en_raw, mem_w_en_raw, dest_out, pc_out,
            alu_res_out, val_rm_out} = out_data;

    // Stale payload may sit in main after a flush; only the control bits
    // must be clean, so they are qualified with out_valid.
    assign wb_en_out    = wb_en_raw    & out_valid;
    assign mem_r_en_out = mem_r_en_raw & out_valid;
    assign mem_w_en_out = mem_w_en_raw & out_valid;

`ifdef EXE_MEM_PERF_EN
    // Stall and bubble counters; wrap freely, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready) stall_cnt  <= stall_cnt + 32'd1;
            if (!out_valid)              bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/exe_mem_pipe_buf.md
# exe_mem_pipe_buf

Parametrised EXE→MEM pipeline stage with a valid/ready handshake and a one-entry skid buffer. It replaces the plain enable/clear EXE/MEM register, which has no backpressure. MEM can now stall without a combinational ready path back into EXE, and a branch or exception flush squashes in-flight instructions. It carries writeback/memory control bits, destination register, PC, ALU result and Rm value.

## Interface
Reset is synchronous and active-high; one clock.
- DATA_W, 32, width of alu_res and val_rm
- DEST_W, 4, destination register index width
- PC_W, 32, program counter width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- flush  in  1  squash all held entries; drop this cycle's input
- in_valid  in  1  EXE presents an instruction
- in_ready  out  1  stage can accept; driven directly from state flops
- wb_en_in, mem_r_en_in, mem_w_en_in  in  1 each  control bits
- dest_in  in  DEST_W  destination register
- pc_in  in  PC_W  instruction PC
- alu_res_in, val_rm_in  in  DATA_W each  ALU result, store data
- out_valid  out  1  MEM-side entry valid
- out_ready  in  1  MEM consumes this cycle
- wb_en_out, mem_r_en_out, mem_w_en_out  out  1 each  forced 0 when out_valid=0
- dest_out  out  DEST_W, pc_out  out  PC_W, alu_res_out, val_rm_out  out  DATA_W  payload of head entry

## Operation
- accept = in_valid & in_ready & ~flush; pop = out_valid & out_ready.
- The block has two slots: main, which drives the outputs, and skid. Its states are EMPTY, ONE and FULL.
- EMPTY: accept → ONE, main←input.
- ONE:
  - accept & pop → ONE, main←input.
  - accept & ~pop → FULL, skid←input.
  - ~accept & pop → EMPTY.
  - Otherwise hold.
- FULL: pop → ONE, main←skid. in_ready=0, so no accept in FULL.
- in_ready = (state != FULL). It never depends combinationally on out_ready or in_valid.
- out_valid = (state != EMPTY).
- flush: next state is EMPTY regardless of accept/pop, and control outputs go to 0 next cycle. A pop in the flush cycle still counts as consumed by MEM. Payload data fields may hold stale values.
- rst has priority over flush, and flush over everything else.
- Ordering is strictly FIFO: the skid entry is never overtaken by a new input.

## Timing
- Latency is 1 cycle: an input accepted at edge N appears on the outputs after edge N when the stage was EMPTY, or was ONE with a pop.
- Sustained throughput is 1 instruction per cycle while out_ready=1.
- After any stall, at most 1 extra instruction is absorbed: the one accepted in the cycle out_ready fell.
- Reset values: state EMPTY, out_valid=0, in_ready=1, all control outputs 0, dest_out/pc_out/alu_res_out/val_rm_out=0, skid slot 0.
- Reset mid-operation discards both entries at the next edge; there is no partial drain.
- in_ready falls the cycle after entering FULL and rises the cycle after the pop from FULL.

## Configuration
- EXE_MEM_PERF_EN defined: adds two outputs.
  - stall_cnt [31:0]: increments on cycles with out_valid & ~out_ready.
  - bubble_cnt [31:0]: increments on cycles with ~out_valid & ~rst.
  - Both wrap modulo 2^32, are cleared only by rst, and are unaffected by flush.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package exe_mem_pkg holds:
  - typedef exe_mem_payload_t, a packed struct of wb_en, mem_r_en, mem_w_en, dest, pc, alu_res, val_rm, sized from the package-level defaults;
  - the state enum {EMPTY, ONE, FULL}.
- One sub-module, pipe_skid_buf (parameter W), implements the generic two-slot handshake on a flat vector. The top packs and unpacks the payload, gates the control bits with out_valid, and hosts the perf counters.

## Test plan
- Reset, then in_valid=1 with alu_res_in=0x1234, dest_in=3, out_ready=1 → next cycle out_valid=1, alu_res_out=0x1234, dest_out=3, in_ready=1.
- Stream pc_in=0x100, 0x104, 0x108 back-to-back with out_ready=1 → the outputs show the same sequence on consecutive cycles with no bubble.
- Hold out_ready=0 and offer A, B, C → A is in main, B in skid, in_ready=0 from the third cycle, C held. Raise out_ready → A, B, C pop in order.
- FULL with mem_w_en=1 entries, pulse flush for one cycle → next cycle out_valid=0, mem_w_en_out=0, in_ready=1. Neither entry appears later.
- Assert rst while FULL with in_valid=1 → next cycle all outputs are 0, in_ready=1, and no entry survives.
- With EXE_MEM_PERF_EN, run 5 cycles of out_valid & ~out_ready and 3 empty cycles → stall_cnt=5, bubble_cnt=3. A flush leaves both unchanged.
